// File: rtl/div_req_ctrl.sv
// rtl/div_req_ctrl.sv - two-lane divide request sequencer in front of a shared iterative divider
// Lane0 is always issued before lane1; zero-divisor lanes are resolved locally without the divider.
module div_req_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ex_go,
  input  logic        lane0_valid,
  input  logic        lane1_valid,
  input  logic        lane0_mod,
  input  logic        lane1_mod,
  input  logic        lane0_unsigned,
  input  logic        lane1_unsigned,
  input  logic [31:0] lane0_x,
  input  logic [31:0] lane0_y,
  input  logic [31:0] lane1_x,
  input  logic [31:0] lane1_y,
  output logic        div_req,
  output logic        div_use_mod,
  output logic        div_unsigned,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  output logic        div_abort,
  input  logic [31:0] div_result,
  input  logic        div_ok,
  output logic        div_stall,
  output logic [31:0] lane0_result,
  output logic [31:0] lane1_result,
  output logic        lane0_done,
  output logic        lane1_done
);

  typedef enum logic [2:0] {S_IDLE, S_BUSY0, S_GAP, S_BUSY1, S_DONE} state_t;

  state_t      r_state;
  logic        r_done0;
  logic        r_done1;
  logic        r_abort;
  logic [31:0] r_res0;
  logic [31:0] r_res1;

  logic        w_need0;
  logic        w_need1;
  logic        w_byp0;
  logic        w_byp1;
  logic        w_busy;
  logic        w_stall;

  assign w_need0 = lane0_valid && (lane0_y != 32'h0);
  assign w_need1 = lane1_valid && (lane1_y != 32'h0);
  assign w_byp0  = lane0_valid && (lane0_y == 32'h0);
  assign w_byp1  = lane1_valid && (lane1_y == 32'h0);
  assign w_busy  = (r_state == S_BUSY0) || (r_state == S_GAP) || (r_state == S_BUSY1);
  assign w_stall = !flush && ((lane0_valid && !r_done0) || (lane1_valid && !r_done1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_abort <= 1'b0;
      r_res0  <= 32'h0;
      r_res1  <= 32'h0;
    end else begin
      r_abort <= 1'b0;
      if (flush) begin
        // Flush beats a simultaneous div_ok: the in-flight result is dropped.
        r_state <= S_IDLE;
        r_done0 <= 1'b0;
        r_done1 <= 1'b0;
        r_abort <= w_busy;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_byp0) begin
              r_res0  <= lane0_mod ? lane0_x : 32'h0;
              r_done0 <= 1'b1;
            end
            if (w_byp1) begin
              r_res1  <= lane1_mod ? lane1_x : 32'h0;
              r_done1 <= 1'b1;
            end
            if (w_need0)
              r_state <= S_BUSY0;
            else if (w_need1)
              r_state <= S_BUSY1;
            else if (lane0_valid || lane1_valid)
              r_state <= S_DONE;
          end
          S_BUSY0: begin
            if (div_ok) begin
              r_res0  <= div_result;
              r_done0 <= 1'b1;
              r_state <= w_need1 ? S_GAP : S_DONE;
            end
          end
          // One idle cycle lets the divider see div_req fall between the two ops.
          S_GAP: r_state <= S_BUSY1;
          S_BUSY1: begin
            if (div_ok) begin
              r_res1  <= div_result;
              r_done1 <= 1'b1;
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            if (ex_go && !w_stall) begin
              r_state <= S_IDLE;
              r_done0 <= 1'b0;
              r_done1 <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    div_use_mod  = 1'b0;
    div_unsigned = 1'b0;
    div_x        = 32'h0;
    div_y        = 32'h0;
    if (r_state == S_BUSY0) begin
      div_use_mod  = lane0_mod;
      div_unsigned = lane0_unsigned;
      div_x        = lane0_x;
      div_y        = lane0_y;
    end else if (r_state == S_BUSY1) begin
      div_use_mod  = lane1_mod;
      div_unsigned = lane1_unsigned;
      div_x        = lane1_x;
      div_y        = lane1_y;
    end
  end

  assign div_req      = ((r_state == S_BUSY0) || (r_state == S_BUSY1)) && !flush;
  assign div_abort    = r_abort;
  assign div_stall    = w_stall;
  assign lane0_result = r_res0;
  assign lane1_result = r_res1;
  assign lane0_done   = r_done0;
  assign lane1_done   = r_done1;

endmodule

// File: tb/tb_div_req_ctrl.sv
// tb/tb_div_req_ctrl.sv - directed bench for div_req_ctrl with a hand-driven divider
// Inputs change 1 time unit after posedge; outputs are sampled a further unit later.
module tb_div_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        ex_go;
  logic        lane0_valid;
  logic        lane1_valid;
  logic        lane0_mod;
  logic        lane1_mod;
  logic        lane0_unsigned;
  logic        lane1_unsigned;
  logic [31:0] lane0_x;
  logic [31:0] lane0_y;
  logic [31:0] lane1_x;
  logic [31:0] lane1_y;
  logic        div_req;
  logic        div_use_mod;
  logic        div_unsigned;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_abort;
  logic [31:0] div_result;
  logic        div_ok;
  logic        div_stall;
  logic [31:0] lane0_result;
  logic [31:0] lane1_result;
  logic        lane0_done;
  logic        lane1_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_req_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .ex_go          (ex_go),
    .lane0_valid    (lane0_valid),
    .lane1_valid    (lane1_valid),
    .lane0_mod      (lane0_mod),
    .lane1_mod      (lane1_mod),
    .lane0_unsigned (lane0_unsigned),
    .lane1_unsigned (lane1_unsigned),
    .lane0_x        (lane0_x),
    .lane0_y        (lane0_y),
    .lane1_x        (lane1_x),
    .lane1_y        (lane1_y),
    .div_req        (div_req),
    .div_use_mod    (div_use_mod),
    .div_unsigned   (div_unsigned),
    .div_x          (div_x),
    .div_y          (div_y),
    .div_abort      (div_abort),
    .div_result     (div_result),
    .div_ok         (div_ok),
    .div_stall      (div_stall),
    .lane0_result   (lane0_result),
    .lane1_result   (lane1_result),
    .lane0_done     (lane0_done),
    .lane1_done     (lane1_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane0(input logic v, input logic m, input logic u,
                           input logic [31:0] x, input logic [31:0] y);
    lane0_valid = v; lane0_mod = m; lane0_unsigned = u; lane0_x = x; lane0_y = y;
  endtask

  task automatic set_lane1(input logic v, input logic m, input logic u,
                           input logic [31:0] x, input logic [31:0] y);
    lane1_valid = v; lane1_mod = m; lane1_unsigned = u; lane1_x = x; lane1_y = y;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; ex_go = 1'b0;
    div_ok = 1'b0; div_result = 32'h0;
    set_lane0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_lane1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'h0, div_req},    32'h0);
    check("rst_abort", {31'h0, div_abort},  32'h0);
    check("rst_stall", {31'h0, div_stall},  32'h0);
    check("rst_res0",  lane0_result,        32'h0);
    check("rst_res1",  lane1_result,        32'h0);
    check("rst_done",  {30'h0, lane1_done, lane0_done}, 32'h0);
    resetn = 1'b1;
    tick();

    // signed 100 / -7 on lane0 only
    set_lane0(1'b1, 1'b0, 1'b0, 32'd100, 32'hFFFF_FFF9);
    #1;
    check("t1_stall_idle", {31'h0, div_stall}, 32'h1);
    check("t1_req_idle",   {31'h0, div_req},   32'h0);
    tick();
    check("t1_req",   {31'h0, div_req},      32'h1);
    check("t1_x",     div_x,                 32'd100);
    check("t1_y",     div_y,                 32'hFFFF_FFF9);
    check("t1_ops",   {30'h0, div_use_mod, div_unsigned}, 32'h0);
    tick();
    check("t1_req_hold", {31'h0, div_req}, 32'h1);
    check("t1_x_hold",   div_x,            32'd100);
    div_ok = 1'b1; div_result = 32'hFFFF_FFF2;
    tick();
    div_ok = 1'b0; div_result = 32'h0;
    check("t1_res0",  lane0_result,          32'hFFFF_FFF2);
    check("t1_done0", {31'h0, lane0_done},   32'h1);
    check("t1_stall", {31'h0, div_stall},    32'h0);
    check("t1_req_done", {31'h0, div_req},   32'h0);
    ex_go = 1'b1;
    tick();
    ex_go = 1'b0;
    check("t1_done0_clr", {31'h0, lane0_done}, 32'h0);
    lane0_valid = 1'b0;
    #1;
    check("t1_stall_idle2", {31'h0, div_stall}, 32'h0);

    // unsigned 100 mod 7, then signed -9 / 2 after one gap cycle
    set_lane0(1'b1, 1'b1, 1'b1, 32'd100, 32'd7);
    set_lane1(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF7, 32'd2);
    tick();
    check("t2_ops0", {30'h0, div_use_mod, div_unsigned}, 32'h3);
    check("t2_y0",   div_y, 32'd7);
    div_ok = 1'b1; div_result = 32'd2;
    tick();
    div_ok = 1'b0;
    check("t2_gap_req", {31'h0, div_req},    32'h0);
    check("t2_res0",    lane0_result,        32'd2);
    check("t2_done0",   {31'h0, lane0_done}, 32'h1);
    check("t2_stall",   {31'h0, div_stall},  32'h1);
    ex_go = 1'b1;
    tick();
    ex_go = 1'b0;
    check("t2_req1",  {31'h0, div_req}, 32'h1);
    check("t2_x1",    div_x,            32'hFFFF_FFF7);
    check("t2_y1",    div_y,            32'd2);
    check("t2_ops1",  {30'h0, div_use_mod, div_unsigned}, 32'h0);
    div_ok = 1'b1; div_result = 32'hFFFF_FFFC;
    tick();
    div_ok = 1'b0;
    check("t2_res1",  lane1_result,        32'hFFFF_FFFC);
    check("t2_done1", {31'h0, lane1_done}, 32'h1);
    check("t2_stall_done", {31'h0, div_stall}, 32'h0);
    ex_go = 1'b1;
    tick();
    ex_go = 1'b0;
    lane0_valid = 1'b0; lane1_valid = 1'b0;

    // both lanes divide by zero: remainder on lane0, quotient on lane1
    set_lane0(1'b1, 1'b1, 1'b0, 32'd55, 32'h0);
    set_lane1(1'b1, 1'b0, 1'b0, 32'd9,  32'h0);
    #1;
    check("t3_req_idle", {31'h0, div_req},   32'h0);
    check("t3_stall",    {31'h0, div_stall}, 32'h1);
    tick();
    check("t3_req",   {31'h0, div_req}, 32'h0);
    check("t3_res0",  lane0_result,     32'd55);
    check("t3_res1",  lane1_result,     32'h0);
    check("t3_done",  {30'h0, lane1_done, lane0_done}, 32'h3);
    check("t3_stall_done", {31'h0, div_stall}, 32'h0);
    ex_go = 1'b1;
    tick();
    ex_go = 1'b0;
    lane0_valid = 1'b0; lane1_valid = 1'b0;

    // flush two cycles into BUSY0
    set_lane0(1'b1, 1'b0, 1'b1, 32'd1000, 32'd10);
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("t4_req_flush",   {31'h0, div_req},   32'h0);
    check("t4_stall_flush", {31'h0, div_stall}, 32'h0);
    tick();
    flush = 1'b0;
    check("t4_abort", {31'h0, div_abort},  32'h1);
    check("t4_done0", {31'h0, lane0_done}, 32'h0);
    check("t4_res0",  lane0_result,        32'd55);
    lane0_valid = 1'b0;
    tick();
    check("t4_abort_end", {31'h0, div_abort}, 32'h0);
    check("t4_req_idle",  {31'h0, div_req},   32'h0);

    // div_ok and flush together in BUSY1
    set_lane1(1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    tick();
    check("t5_req", {31'h0, div_req}, 32'h1);
    check("t5_x",   div_x,            32'd50);
    div_ok = 1'b1; div_result = 32'd10; flush = 1'b1;
    tick();
    div_ok = 1'b0; flush = 1'b0;
    check("t5_done1", {31'h0, lane1_done}, 32'h0);
    check("t5_res1",  lane1_result,        32'h0);
    check("t5_abort", {31'h0, div_abort},  32'h1);
    lane1_valid = 1'b0;
    tick();

    // overflow operands forwarded untouched; reset mid-BUSY1 then re-issue
    set_lane1(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    check("t6_x",   div_x, 32'h8000_0000);
    check("t6_y",   div_y, 32'hFFFF_FFFF);
    check("t6_uns", {31'h0, div_unsigned}, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_req",  {31'h0, div_req},   32'h0);
    check("t6_rst_abort",{31'h0, div_abort}, 32'h0);
    check("t6_rst_res0", lane0_result,       32'h0);
    check("t6_rst_res1", lane1_result,       32'h0);
    check("t6_rst_done", {30'h0, lane1_done, lane0_done}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("t6_idle_req", {31'h0, div_req}, 32'h0);
    tick();
    check("t6_reissue", {31'h0, div_req}, 32'h1);
    check("t6_x2",      div_x,            32'h8000_0000);
    div_ok = 1'b1; div_result = 32'h8000_0000;
    tick();
    div_ok = 1'b0;
    check("t6_res1",  lane1_result,        32'h8000_0000);
    check("t6_done1", {31'h0, lane1_done}, 32'h1);
    ex_go = 1'b1;
    tick();
    ex_go = 1'b0;
    lane1_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_req_ctrl.md
DIV_REQ_CTRL -- requirements
Module: div_req_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 flush  in  1  EX-stage flush; kills both lanes' divide operations.
REQ-005 ex_go  in  1  EX stage advances this cycle; retires captured results.
REQ-006 lane0_valid / lane1_valid  in  1 each  lane holds a divide op (lane0 older).
REQ-007 lane0_mod / lane1_mod  in  1 each  1 = remainder, 0 = quotient.
REQ-008 lane0_unsigned / lane1_unsigned  in  1 each  1 = unsigned, 0 = signed.
REQ-009 lane0_x, lane0_y, lane1_x, lane1_y  in  32 each  dividend, divisor.
REQ-010 div_req  out  1  request to divider; operand bus valid.
REQ-011 div_use_mod, div_unsigned  out  1 each  op fields to divider.
REQ-012 div_x, div_y  out  32 each  operands to divider.
REQ-013 div_abort  out  1  one-cycle abort pulse to divider flush input.
REQ-014 div_result  in  32  divider result.
REQ-015 div_ok  in  1  divider done; meaningful only while div_req = 1.
REQ-016 div_stall  out  1  holds EX stage; combinational.
REQ-017 lane0_result / lane1_result  out  32 each  captured results.
REQ-018 lane0_done / lane1_done  out  1 each  result valid for that lane.

Function
REQ-019 FSM states SHALL be IDLE, BUSY0, GAP, BUSY1, DONE.
REQ-020 A lane SHALL need the divider iff lane_valid = 1 and lane_y != 0.
REQ-021 Zero-divisor lanes SHALL bypass divider: quotient = 32'h0, remainder = lane_x; done set next cycle.
REQ-022 IDLE: lane0 needs divider -> BUSY0; else lane1 needs divider -> BUSY1; else any valid lane -> DONE; else stay.
REQ-023 div_req SHALL equal 1 in BUSY0/BUSY1 and flush = 0; 0 in all other states.
REQ-024 In BUSY0, div_x/div_y/div_use_mod/div_unsigned SHALL equal lane0 fields; in BUSY1, lane1; else 0.
REQ-025 Operands SHALL stay stable every cycle div_req = 1 until div_ok sampled high.
REQ-026 BUSY0 with div_ok = 1: capture div_result into lane0_result, set lane0_done; go GAP if lane1 needs divider, else DONE.
REQ-027 GAP SHALL hold div_req = 0 exactly one cycle, then -> BUSY1.
REQ-028 BUSY1 with div_ok = 1: capture into lane1_result, set lane1_done, -> DONE.
REQ-029 Bypass lanes SHALL set done/result on leaving IDLE (or GAP for lane1) with no divider traffic.
REQ-030 div_stall SHALL be 1 while any valid lane lacks done, and 0 when no valid lane or flush = 1.
REQ-031 DONE SHALL hold results and done flags until ex_go = 1, then -> IDLE with done flags cleared.
REQ-032 ex_go asserted while div_stall = 1 SHALL be ignored.
REQ-033 flush SHALL force IDLE next cycle, clear done flags, and pulse div_abort = 1 for one cycle if state was BUSY0, GAP or BUSY1.
REQ-034 flush and div_ok in the same cycle: flush SHALL win; result discarded.
REQ-035 Signed 32'h80000000 / 32'hFFFFFFFF SHALL be forwarded to divider unmodified.
REQ-036 Latency: lane result visible the cycle after div_ok; bypass-only pair done 1 cycle after entering IDLE.

Reset
REQ-037 resetn = 0 SHALL asynchronously force IDLE, all results 32'h0, all done 0, div_req 0, div_abort 0.
REQ-038 resetn deasserted mid-division SHALL leave the block in IDLE; pending ops re-issue from lane inputs.

Verification
REQ-039 lane0 signed 100 / -7 div, lane1 invalid -> div_req one op, lane0_result 32'hFFFFFFF2, stall drops next cycle.
REQ-040 lane0 unsigned 100 mod 7, lane1 signed -9 / 2 div -> lane0_result 2, one GAP cycle with div_req 0, lane1_result 32'hFFFFFFFC.
REQ-041 lane0 x = 55, y = 0, mod -> no div_req, lane0_result 55, lane0_done after 1 cycle.
REQ-042 flush two cycles into BUSY0 -> div_req 0 same cycle, div_abort one pulse, IDLE, no done.
REQ-043 div_ok and flush same cycle in BUSY1 -> lane1_done stays 0, results discarded.
REQ-044 resetn low during BUSY1 -> all outputs 0 immediately, IDLE after release.
